uart_rx_controller: RTL and testbench

//  Receive-side sequencer for the UART; counterpart of the TX controller.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_controller_if.sv | 11 +
 rtl/uart_rx_sync.sv | 19 +
 rtl/uart_rx_controller.sv | 140 ++++++++++++++
 tb/tb_uart_rx_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP_1,
        RX_STOP_2,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Write port from the receive sequencer into the RX queue.
interface uart_rx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_queue_we;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_queue_full;

    modport master (output rx_queue_we, output rx_data, input rx_queue_full);
    modport slave  (input rx_queue_we, input rx_data, output rx_queue_full);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: frames start/data/parity/stop on oversample ticks,
// writes words to the RX queue and keeps sticky parity/frame/overrun flags.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_clk_en,
    input  logic                        rx,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        double_stop_bit,
    input  logic                        err_clr,
    uart_rx_controller_if.master        rxq,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun_err
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] CNT_MID  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] CNT_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
    logic                 par_acc;
    logic                 par_bad;
    logic                 frm_bad;
    logic                 cfg_par_en;
    logic                 cfg_par_odd;
    logic                 cfg_dstop;
    logic                 mid;
    logic                 commit;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign mid       = rx_clk_en && (sample_cnt == CNT_MID);
    assign commit    = mid && ((state == RX_STOP_1 && !cfg_dstop) || state == RX_STOP_2);
    // A low first stop bit of a two-stop frame is remembered in frm_bad until commit.
    assign frame_bad = frm_bad || !rx_s;

    assign rxq.rx_queue_we = commit && !rxq.rx_queue_full;
    assign rxq.rx_data     = shift_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_acc     <= 1'b0;
            par_bad     <= 1'b0;
            frm_bad     <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_dstop   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= (commit && par_bad)   || (parity_err  && !err_clr);
            frame_err   <= (commit && frame_bad) || (frame_err   && !err_clr);
            overrun_err <= (commit && rxq.rx_queue_full) || (overrun_err && !err_clr);

            if (rx_clk_en) begin
                sample_cnt <= (sample_cnt == CNT_MID) ? '0 : sample_cnt + 1'b1;
                case (state)
                    RX_IDLE: begin
                        sample_cnt <= '0;
                        if (!rx_s) state <= RX_START;
                    end
                    RX_START: begin
                        if (sample_cnt == CNT_HALF) begin
                            sample_cnt <= '0;
                            if (!rx_s) begin
                                state       <= RX_DATA;
                                bit_cnt     <= '0;
                                par_acc     <= 1'b0;
                                par_bad     <= 1'b0;
                                frm_bad     <= 1'b0;
                                cfg_par_en  <= parity_en;
                                cfg_par_odd <= parity_odd;
                                cfg_dstop   <= double_stop_bit;
                            end else begin
                                state <= RX_IDLE;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (sample_cnt == CNT_MID) begin
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            par_acc   <= par_acc ^ rx_s;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST)
                                state <= cfg_par_en ? RX_PARITY : RX_STOP_1;
                        end
                    end
                    RX_PARITY: begin
                        if (sample_cnt == CNT_MID) begin
                            par_bad <= ((par_acc ^ rx_s) != cfg_par_odd);
                            state   <= RX_STOP_1;
                        end
                    end
                    RX_STOP_1: begin
                        if (sample_cnt == CNT_MID) begin
                            if (cfg_dstop) begin
                                frm_bad <= !rx_s;
                                state   <= RX_STOP_2;
                            end else begin
                                state <= frame_bad ? RX_WAIT_HIGH : RX_IDLE;
                            end
                        end
                    end
                    RX_STOP_2: begin
                        if (sample_cnt == CNT_MID)
                            state <= frame_bad ? RX_WAIT_HIGH : RX_IDLE;
                    end
                    RX_WAIT_HIGH: begin
                        sample_cnt <= '0;
                        if (rx_s) state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomised frame-level bench with a write scoreboard for uart_rx_controller.
module tb_uart_rx_controller;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset;
    logic rx_clk_en;
    logic rx;
    logic parity_en;
    logic parity_odd;
    logic double_stop_bit;
    logic err_clr;
    logic parity_err;
    logic frame_err;
    logic overrun_err;

    uart_rx_controller_if #(.DATA_BITS(8)) rxq ();

    uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_clk_en       (rx_clk_en),
        .rx              (rx),
        .parity_en       (parity_en),
        .parity_odd      (parity_odd),
        .double_stop_bit (double_stop_bit),
        .err_clr         (err_clr),
        .rxq             (rxq.slave),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .overrun_err     (overrun_err)
    );

    always #5 clk = ~clk;

    int tcnt = 0;
    initial begin
        rx_clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rx_clk_en = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] sb[$];
    logic exp_par = 1'b0, exp_frm = 1'b0, exp_ovr = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && rxq.rx_queue_we === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_write: got data 0x%02h with no frame pending", rxq.rx_data);
                end else begin
                    chk("rx_data", rxq.rx_data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (!rx_clk_en);
        end
        #2;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, " parity_err"},  {7'd0, parity_err},  {7'd0, exp_par});
        chk({tag, " frame_err"},   {7'd0, frame_err},   {7'd0, exp_frm});
        chk({tag, " overrun_err"}, {7'd0, overrun_err}, {7'd0, exp_ovr});
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // One complete frame; expectations come from the frame description alone.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pflip,
                              input bit stop1, input bit stop2, input bit dstop,
                              input bit full, input bit clr_at_commit, input bit toggle_mid);
        bit pbit, ev_par, ev_frm;
        parity_en       = pen;
        parity_odd      = podd;
        double_stop_bit = dstop;
        rxq.rx_queue_full = full;
        pbit   = (^d) ^ podd ^ pflip;
        ev_par = pen && pflip;
        ev_frm = !stop1 || (dstop && !stop2);
        if (!full) sb.push_back(d);

        rx = 1'b0;
        tick_wait(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_wait(OS);
            if (toggle_mid && i == 3) begin
                double_stop_bit = ~double_stop_bit;
                parity_en       = ~parity_en;
                parity_odd      = ~parity_odd;
            end
        end
        if (pen) begin
            rx = pbit;
            tick_wait(OS);
        end
        rx = stop1;
        if (dstop) begin
            tick_wait(OS);
            rx = stop2;
        end
        if (clr_at_commit) begin
            tick_wait(OS / 2);
            do @(negedge clk); while (!rx_clk_en);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            tick_wait(OS / 2 - 1);
            exp_par = ev_par;
            exp_frm = ev_frm;
            exp_ovr = full;
        end else begin
            tick_wait(OS);
            exp_par = exp_par | ev_par;
            exp_frm = exp_frm | ev_frm;
            exp_ovr = exp_ovr | full;
        end
        rxq.rx_queue_full = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        rx = 1'b1;
        tick_wait(n);
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        double_stop_bit = 1'b0;
        err_clr = 1'b0;
        rxq.rx_queue_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset rx_queue_we", {7'd0, rxq.rx_queue_we}, 8'd0);
        chk("reset rx_data", rxq.rx_data, 8'd0);
        check_flags("reset");
        reset = 1'b0;
        idle_gap(3);

        // 8N1
        send_frame(8'h55, 0, 0, 0, 1, 1, 0, 0, 0, 0); idle_gap(3);
        check_flags("8N1 0x55");

        // even parity, good then bad parity bit
        send_frame(8'hA3, 1, 0, 0, 1, 1, 0, 0, 0, 0); idle_gap(3);
        check_flags("parity good");
        send_frame(8'hA3, 1, 0, 1, 1, 1, 0, 0, 0, 0); idle_gap(3);
        check_flags("parity bad");
        pulse_clr();

        // short glitch rejected, then a clean frame
        rx = 1'b0;
        tick_wait(3);
        idle_gap(12);
        check_flags("glitch");
        send_frame(8'hC5, 0, 0, 0, 1, 1, 0, 0, 0, 0); idle_gap(3);

        // stop bit low and line held low: one write, no retrigger
        send_frame(8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick_wait(40);
        idle_gap(3);
        check_flags("break");
        send_frame(8'h7E, 0, 0, 0, 1, 1, 0, 0, 0, 0); idle_gap(3);
        check_flags("after break");
        pulse_clr();

        // overrun, then clear coinciding with a new overrun
        send_frame(8'h3C, 0, 0, 0, 1, 1, 0, 1, 0, 0); idle_gap(3);
        check_flags("overrun");
        send_frame(8'h3D, 0, 0, 0, 1, 1, 0, 1, 1, 0); idle_gap(3);
        check_flags("overrun clr race");

        // reset in the 4th data bit of 0xFF aborts the frame
        rx = 1'b0;
        tick_wait(OS);
        rx = 1'b1;
        tick_wait(3 * OS + OS / 2);
        do_reset();
        idle_gap(3);
        check_flags("mid-frame reset");
        send_frame(8'h12, 0, 0, 0, 1, 1, 0, 0, 0, 0); idle_gap(3);
        check_flags("after reset");

        // two stop bits, second sampled low
        send_frame(8'h96, 0, 0, 0, 1, 0, 1, 0, 0, 0); idle_gap(3);
        check_flags("2nd stop low");
        pulse_clr();
        // config toggled mid-frame must be ignored
        send_frame(8'h69, 0, 0, 0, 1, 0, 1, 0, 0, 1); idle_gap(3);
        check_flags("mid-frame config toggle");

        // randomised frames
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            bit pen, podd, pflip, s1, s2, ds, full, clr;
            d     = 8'($urandom);
            pen   = 1'($urandom);
            podd  = 1'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            s1    = ($urandom_range(0, 5) != 0);
            s2    = ($urandom_range(0, 5) != 0);
            ds    = 1'($urandom);
            full  = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 7) == 0);
            send_frame(d, pen, podd, pflip, s1, s2, ds, full, clr, 0);
            idle_gap(2 + $urandom_range(0, 4));
            check_flags("random");
        end

        repeat (20) @(negedge clk);
        chk("pending writes", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
